keypad_cmd_gen: RTL and testbench
=================================

Name: keypad_cmd_gen

Overview:
- Upstream stage of the calculator: scans a 4x4 matrix keypad, synchronises and debounces it, and maps each key to the 4-bit command code consumed by `calc`.
- Each accepted key press is delivered as exactly one single-cycle command on `cmd`.
- Delivery is held off while `calc` reports busy on `status`.
- Between commands `cmd` sits at the idle code, so `calc` sees no spurious input.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before advancing to the next column.
- DEBOUNCE_CYC, 20000: consecutive cycles the same key must be seen before it is accepted.
- IDLE_CODE, 4'hF: value on `cmd` when no command is issued.
- BUSY_STATUS, 2'b01: `status` value meaning `calc` cannot accept a command.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rows  in  4  keypad row lines; pulled up, 0 = pressed; asynchronous to `clock`.
- cols  out  4  keypad column drive, active-low; exactly one bit low at a time.
- status  in  2  status from `calc`.
- cmd  out  4  command to `calc`; a code for one cycle, otherwise IDLE_CODE.
- key_held  out  1  high while a debounced key is held (debug/LED).

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - cols=4'b1110, cmd=IDLE_CODE, key_held=0;
  - FSM=SCAN, scan and debounce counters cleared, pending code cleared.
- Reset mid-operation discards any pending command; no command is issued after reset releases.
- Synchroniser: `rows` pass through a 2-flop synchroniser before use. All decisions use the synchronised value, so press-to-detect latency is +2 cycles.
- Scan:
  - A column counter col_idx (0..3) advances every SCAN_DIV cycles and wraps 3->0.
  - cols = ~(1<<col_idx).
  - A key is "seen" when exactly one synchronised row bit is 0 in the current column.
  - Zero or multiple low rows in the column count as no key (ghosting rejection).
- Key code: pos = {row_idx, col_idx}. The fixed map lives in the package:
  - row0: 1,2,3,+
  - row1: 4,5,6,-
  - row2: 7,8,9,*
  - row3: C,0,=, reserved
  - The reserved key maps to IDLE_CODE. It is never issued but is still debounced and release-waited.
- FSM states SCAN, DEBOUNCE, ISSUE, RELEASE:
  - SCAN: on a seen key, latch pos, freeze the column counter, clear the debounce counter, go to DEBOUNCE.
  - DEBOUNCE: the counter increments each cycle the same pos is seen.
    - Any other observation (no key, different key, multiple rows) returns to SCAN and resumes column advance.
    - When the count reaches DEBOUNCE_CYC-1, go to ISSUE and set key_held=1.
  - ISSUE:
    - If status != BUSY_STATUS, drive cmd=code for exactly one cycle, then go to RELEASE.
    - If status == BUSY_STATUS, wait. The latched code is held even if the key is released meanwhile.
    - A busy-to-ready transition in cycle N produces the command in cycle N+1 (registered output).
  - RELEASE: column stays frozen. Return to SCAN only after no row is low for DEBOUNCE_CYC consecutive cycles; at that point key_held=0.
  - Holding a key never auto-repeats.
- Latency: stable press to `cmd` pulse = 2 (sync) + DEBOUNCE_CYC + 1 cycles when not busy. Add up to 4*SCAN_DIV cycles if the column was not yet being scanned.
- Counters: scan counter is ceil(log2(SCAN_DIV)) bits; debounce counter is ceil(log2(DEBOUNCE_CYC)) bits. Neither counter may overflow or wrap.
- `cmd` is fully registered; no combinational path from `rows` or `status` to `cmd`.

Decomposition:
- Package calc_pkg holds:
  - command code constants: digits 0-9 = 4'h0-4'h9, ADD=4'hA, SUB=4'hB, MUL=4'hC, EQ=4'hD, CLR=4'hE, IDLE=4'hF;
  - status encodings;
  - the keymap function pos -> code;
  - the FSM state enum typedef.
- One sub-module, sync2: a 2-flop synchroniser, parameterised width, same active-low asynchronous reset.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8):
- Reset: assert reset=0 mid-scan -> cols=4'b1110, cmd=4'hF immediately; after release, scanning resumes from column 0.
- Clean press of row1/col2 ("6") held 40 cycles, status=2'b00 -> exactly one cmd=4'h6 pulse, 11 cycles after the column is active; key_held rises with it and falls 8 cycles after release.
- Bounce: toggle the row 0/1 every 3 cycles for 30 cycles, then hold stable -> no command during bounce; one command after 8 stable cycles.
- Busy hold-off: press "=" (row3/col2) while status=2'b01 for 50 cycles, releasing the key at cycle 20 -> cmd stays 4'hF throughout busy; cmd=4'hD exactly one cycle after status returns to 2'b00.
- Ghost/reserved keys:
  - two rows low in the same column -> no command;
  - reserved key (row3/col3) -> no command and key_held=1 while held.
- Long hold of "+" for 500 cycles -> a single cmd=4'hA; no repeats.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: command codes, status
// encodings, keypad map and the keypad FSM state type.
package calc_pkg;

  localparam logic [3:0] CMD_0    = 4'h0;
  localparam logic [3:0] CMD_1    = 4'h1;
  localparam logic [3:0] CMD_2    = 4'h2;
  localparam logic [3:0] CMD_3    = 4'h3;
  localparam logic [3:0] CMD_4    = 4'h4;
  localparam logic [3:0] CMD_5    = 4'h5;
  localparam logic [3:0] CMD_6    = 4'h6;
  localparam logic [3:0] CMD_7    = 4'h7;
  localparam logic [3:0] CMD_8    = 4'h8;
  localparam logic [3:0] CMD_9    = 4'h9;
  localparam logic [3:0] CMD_ADD  = 4'hA;
  localparam logic [3:0] CMD_SUB  = 4'hB;
  localparam logic [3:0] CMD_MUL  = 4'hC;
  localparam logic [3:0] CMD_EQ   = 4'hD;
  localparam logic [3:0] CMD_CLR  = 4'hE;
  localparam logic [3:0] CMD_IDLE = 4'hF;

  localparam logic [1:0] STATUS_READY = 2'b00;
  localparam logic [1:0] STATUS_BUSY  = 2'b01;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_ISSUE,
    ST_RELEASE
  } kp_state_e;

  // pos = {row_idx, col_idx}; the bottom-right key is reserved and maps to idle.
  function automatic logic [3:0] keymap(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'h0:    code = CMD_1;
      4'h1:    code = CMD_2;
      4'h2:    code = CMD_3;
      4'h3:    code = CMD_ADD;
      4'h4:    code = CMD_4;
      4'h5:    code = CMD_5;
      4'h6:    code = CMD_6;
      4'h7:    code = CMD_SUB;
      4'h8:    code = CMD_7;
      4'h9:    code = CMD_8;
      4'hA:    code = CMD_9;
      4'hB:    code = CMD_MUL;
      4'hC:    code = CMD_CLR;
      4'hD:    code = CMD_0;
      4'hE:    code = CMD_EQ;
      default: code = CMD_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for signals arriving asynchronously to clock.
module sync2 #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_cmd_gen.sv
// 4x4 keypad scanner: synchronises and debounces the rows, then issues one
// single-cycle command per accepted key press, holding off while calc is busy.
module keypad_cmd_gen
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 20000,
  parameter logic [3:0]  IDLE_CODE    = CMD_IDLE,
  parameter logic [1:0]  BUSY_STATUS  = STATUS_BUSY
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  input  logic [1:0] status,
  output logic [3:0] cmd,
  output logic       key_held
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);
  // Rows only reflect a new column two cycles after it is driven (synchroniser
  // delay), so scan decisions are suppressed until then; needs SCAN_DIV >= 3.
  localparam logic [SCAN_W-1:0] SETTLE_CYC = SCAN_W'(2);

  kp_state_e         state_q;
  logic [1:0]        colIdx_q;
  logic [SCAN_W-1:0] scanCnt_q;
  logic [DEB_W-1:0]  dbCnt_q;
  logic [3:0]        pos_q;
  logic [3:0]        cmd_q;
  logic              keyHeld_q;

  logic [3:0]        rowsSync;
  logic              keySeen;
  logic [1:0]        rowIdx;
  logic [3:0]        scanPos;
  logic              settled;
  logic [DEB_W-1:0]  dbInc;
  logic [3:0]        issueCode;

  sync2 #(
    .WIDTH    (4),
    .RESET_VAL(4'hF)
  ) u_rowSync (
    .clock(clock),
    .reset(reset),
    .d_i  (rows),
    .q_o  (rowsSync)
  );

  // Exactly one low row is a key; none or several low rows (ghosting) is no key.
  always_comb begin
    keySeen = 1'b1;
    rowIdx  = 2'd0;
    case (rowsSync)
      4'b1110: rowIdx = 2'd0;
      4'b1101: rowIdx = 2'd1;
      4'b1011: rowIdx = 2'd2;
      4'b0111: rowIdx = 2'd3;
      default: keySeen = 1'b0;
    endcase
  end

  assign scanPos   = {rowIdx, colIdx_q};
  assign settled   = (scanCnt_q >= SETTLE_CYC);
  assign dbInc     = dbCnt_q + DEB_W'(1);
  assign issueCode = (keymap(pos_q) == CMD_IDLE) ? IDLE_CODE : keymap(pos_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SCAN;
      colIdx_q  <= 2'd0;
      scanCnt_q <= '0;
      dbCnt_q   <= '0;
      pos_q     <= 4'd0;
      cmd_q     <= IDLE_CODE;
      keyHeld_q <= 1'b0;
    end else begin
      cmd_q <= IDLE_CODE;
      unique case (state_q)
        ST_SCAN: begin
          if (keySeen && settled) begin
            pos_q   <= scanPos;
            dbCnt_q <= '0;
            state_q <= ST_DEBOUNCE;
          end else if (scanCnt_q == SCAN_LAST) begin
            scanCnt_q <= '0;
            colIdx_q  <= colIdx_q + 2'd1;
          end else begin
            scanCnt_q <= scanCnt_q + SCAN_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (keySeen && (scanPos == pos_q)) begin
            dbCnt_q <= dbInc;
            if (dbInc == DEB_LAST) begin
              state_q   <= ST_ISSUE;
              keyHeld_q <= 1'b1;
            end
          end else begin
            state_q <= ST_SCAN;
          end
        end
        ST_ISSUE: begin
          if (status != BUSY_STATUS) begin
            cmd_q   <= issueCode;
            dbCnt_q <= '0;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (rowsSync != 4'hF) begin
            dbCnt_q <= '0;
          end else if (dbCnt_q == DEB_LAST) begin
            dbCnt_q   <= '0;
            keyHeld_q <= 1'b0;
            state_q   <= ST_SCAN;
          end else begin
            dbCnt_q <= dbInc;
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign cols     = ~(4'b0001 << colIdx_q);
  assign cmd      = cmd_q;
  assign key_held = keyHeld_q;

endmodule

// File: tb/tb_keypad_cmd_gen.sv
// Directed bench for keypad_cmd_gen with a combinational 4x4 keypad model
// and small scan/debounce parameters.
module tb_keypad_cmd_gen;

  logic        clock;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [1:0]  status;
  logic [3:0]  cmd;
  logic        key_held;
  logic [15:0] keyDown;

  int total = 0;
  int bad = 0;
  int pulseCount = 0;
  logic [3:0] lastCmd = 4'hF;
  int base;

  keypad_cmd_gen #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CYC(8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .rows    (rows),
    .cols    (cols),
    .status  (status),
    .cmd     (cmd),
    .key_held(key_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad: key {r,c} pulls row r low while column c is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keyDown[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clock) begin
    if (cmd !== 4'hF) begin
      pulseCount++;
      lastCmd = cmd;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input logic [1:0] st);
    keyDown = keys;
    status  = st;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitColEnter(input string tag, input logic [3:0] target);
    int n = 0;
    while (cols == target && n < 20) begin tick(1); n++; end
    while (cols != target && n < 40) begin tick(1); n++; end
    checkOutput(tag, {28'd0, cols}, {28'd0, target});
  endtask

  task automatic waitKeyHeld(input string tag, input logic val, input int budget);
    int n = 0;
    while (key_held !== val && n < budget) begin tick(1); n++; end
    checkOutput(tag, {31'd0, key_held}, {31'd0, val});
  endtask

  task automatic waitPulse(input string tag, input logic [3:0] code, input int budget);
    int n = 0;
    while (cmd === 4'hF && n < budget) begin tick(1); n++; end
    checkOutput(tag, {28'd0, cmd}, {28'd0, code});
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(16'h0000, 2'b00);
    tick(3);
    reset = 1'b1;

    // Scan order and asynchronous reset mid-scan
    tick(3);
    checkOutput("scan_col0", {28'd0, cols}, 32'hE);
    tick(1);
    checkOutput("scan_col1", {28'd0, cols}, 32'hD);
    tick(1);
    #3 reset = 1'b0;
    #1;
    checkOutput("rst_cols", {28'd0, cols}, 32'hE);
    checkOutput("rst_cmd", {28'd0, cmd}, 32'hF);
    checkOutput("rst_held", {31'd0, key_held}, 32'h0);
    tick(2);
    reset = 1'b1;
    tick(3);
    checkOutput("resume_col0", {28'd0, cols}, 32'hE);
    tick(1);
    checkOutput("resume_col1", {28'd0, cols}, 32'hD);

    // Clean press of "6": pulse 11 cycles after column 2 becomes active
    base = pulseCount;
    applyStimulus(16'h0040, 2'b00);
    waitColEnter("six_col", 4'b1011);
    tick(9);
    checkOutput("six_held_pre", {31'd0, key_held}, 32'h0);
    tick(1);
    checkOutput("six_held_rise", {31'd0, key_held}, 32'h1);
    checkOutput("six_cmd_pre", {28'd0, cmd}, 32'hF);
    tick(1);
    checkOutput("six_cmd", {28'd0, cmd}, 32'h6);
    tick(1);
    checkOutput("six_cmd_post", {28'd0, cmd}, 32'hF);
    tick(28);
    checkOutput("six_pulses", pulseCount - base, 32'd1);
    checkOutput("six_last", {28'd0, lastCmd}, 32'h6);
    applyStimulus(16'h0000, 2'b00);
    tick(7);
    checkOutput("six_held_after_rel", {31'd0, key_held}, 32'h1);
    tick(5);
    checkOutput("six_held_fall", {31'd0, key_held}, 32'h0);

    // Bouncing "9" never settles, then held stable
    base = pulseCount;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(keyDown ^ 16'h0400, 2'b00);
      tick(3);
      checkOutput("bounce_idle", {28'd0, cmd}, 32'hF);
    end
    checkOutput("bounce_none", pulseCount - base, 32'd0);
    applyStimulus(16'h0400, 2'b00);
    waitPulse("bounce_cmd", 4'h9, 60);
    tick(1);
    checkOutput("bounce_one", pulseCount - base, 32'd1);
    applyStimulus(16'h0000, 2'b00);
    waitKeyHeld("bounce_rel", 1'b0, 40);

    // "=" pressed while calc is busy; key released before busy ends
    applyStimulus(16'h0000, 2'b01);
    waitColEnter("eq_col", 4'b1011);
    base = pulseCount;
    applyStimulus(16'h4000, 2'b01);
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      if (i == 20) begin
        checkOutput("busy_held", {31'd0, key_held}, 32'h1);
        applyStimulus(16'h0000, 2'b01);
      end
      checkOutput("busy_idle", {28'd0, cmd}, 32'hF);
    end
    applyStimulus(16'h0000, 2'b00);
    tick(1);
    checkOutput("busy_eq", {28'd0, cmd}, 32'hD);
    tick(1);
    checkOutput("busy_eq_post", {28'd0, cmd}, 32'hF);
    checkOutput("busy_pulses", pulseCount - base, 32'd1);
    waitKeyHeld("busy_rel", 1'b0, 40);

    // Two rows low in the same column is rejected
    base = pulseCount;
    applyStimulus(16'h0022, 2'b00);
    tick(40);
    checkOutput("ghost_held", {31'd0, key_held}, 32'h0);
    checkOutput("ghost_pulses", pulseCount - base, 32'd0);
    applyStimulus(16'h0000, 2'b00);
    tick(5);

    // Reserved key is debounced and held but never issued
    applyStimulus(16'h8000, 2'b00);
    waitKeyHeld("rsv_held", 1'b1, 40);
    tick(20);
    checkOutput("rsv_still_held", {31'd0, key_held}, 32'h1);
    checkOutput("rsv_pulses", pulseCount - base, 32'd0);
    applyStimulus(16'h0000, 2'b00);
    waitKeyHeld("rsv_rel", 1'b0, 40);
    checkOutput("rsv_pulses_end", pulseCount - base, 32'd0);

    // Long hold of "+" produces a single command
    base = pulseCount;
    applyStimulus(16'h0008, 2'b00);
    tick(500);
    checkOutput("plus_pulses", pulseCount - base, 32'd1);
    checkOutput("plus_last", {28'd0, lastCmd}, 32'hA);
    checkOutput("plus_held", {31'd0, key_held}, 32'h1);
    applyStimulus(16'h0000, 2'b00);
    waitKeyHeld("plus_rel", 1'b0, 40);

    // Reset while a command waits on busy discards it
    applyStimulus(16'h0010, 2'b01);
    waitKeyHeld("pend_held", 1'b1, 40);
    base = pulseCount;
    #2 reset = 1'b0;
    #1;
    checkOutput("pend_rst_cmd", {28'd0, cmd}, 32'hF);
    checkOutput("pend_rst_held", {31'd0, key_held}, 32'h0);
    applyStimulus(16'h0000, 2'b00);
    tick(2);
    reset = 1'b1;
    tick(40);
    checkOutput("pend_discard", pulseCount - base, 32'd0);
    checkOutput("pend_held_end", {31'd0, key_held}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
